// File: rtl/sbh_adjust_selector.sv
// Sign-bit-hiding adjustment selector: picks the lowest-cost coefficient per group
// and holds the chosen position/delta until the downstream handshake completes.
module sbh_adjust_selector #(
  parameter int GROUP_SIZE = 16,
  parameter int COST_W     = 32,
  parameter int POS_W      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic signed [COST_W-1:0] cost_in,
  input  logic signed [1:0]        change_in,
  input  logic                     last_in,
  input  logic                     hide_needed_in,
  output logic                     adj_valid,
  input  logic                     adj_ready,
  output logic [POS_W-1:0]         adj_pos,
  output logic signed [1:0]        adj_change,
  output logic                     adj_apply,
  output logic                     no_cand_err,
  output logic                     len_err,
  output logic                     overrun_err
);

  localparam logic signed [COST_W-1:0] SENTINEL = {1'b0, {(COST_W-1){1'b1}}};
  localparam logic [POS_W-1:0]         LAST_POS = POS_W'(GROUP_SIZE - 1);
  localparam logic [0:0]               ST_ACCUM = 1'b0;
  localparam logic [0:0]               ST_HOLD  = 1'b1;

  logic [0:0]               r_state;
  logic [POS_W-1:0]         r_cnt;
  logic signed [COST_W-1:0] r_min_cost;
  logic [POS_W-1:0]         r_min_pos;
  logic signed [1:0]        r_min_chg;
  logic [POS_W-1:0]         r_pos;
  logic signed [1:0]        r_chg;
  logic                     r_apply;
  logic                     r_no_cand;
  logic                     r_len;
  logic                     r_ovr;

  logic                     w_take;
  logic signed [COST_W-1:0] w_fin_cost;
  logic [POS_W-1:0]         w_fin_pos;
  logic signed [1:0]        w_fin_chg;
  logic                     w_full;
  logic                     w_done;
  logic                     w_len_bad;
  logic                     w_apply;
  logic                     w_busy;
  logic                     w_load;

  always_comb begin
    // First beat of a group always loads, so no stale minimum leaks across groups
    w_take     = (r_cnt == '0) || (cost_in < r_min_cost);
    w_fin_cost = w_take ? cost_in   : r_min_cost;
    w_fin_pos  = w_take ? r_cnt     : r_min_pos;
    w_fin_chg  = w_take ? change_in : r_min_chg;
    w_full     = (r_cnt == LAST_POS);
    w_done     = valid_in && (last_in || w_full);
    w_len_bad  = valid_in && (last_in != w_full);
    w_apply    = hide_needed_in && (w_fin_cost != SENTINEL);
    w_busy     = (r_state == ST_HOLD) && !adj_ready;
    w_load     = w_done && !w_busy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_ACCUM;
      r_cnt      <= '0;
      r_min_cost <= SENTINEL;
      r_min_pos  <= '0;
      r_min_chg  <= '0;
      r_pos      <= '0;
      r_chg      <= '0;
      r_apply    <= 1'b0;
      r_no_cand  <= 1'b0;
      r_len      <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      if (valid_in) begin
        r_cnt <= w_done ? '0 : r_cnt + 1'b1;
        if (w_take) begin
          r_min_cost <= cost_in;
          r_min_pos  <= r_cnt;
          r_min_chg  <= change_in;
        end
      end
      if (w_done && hide_needed_in && (w_fin_cost == SENTINEL)) r_no_cand <= 1'b1;
      if (w_len_bad) r_len <= 1'b1;
      if (w_done && w_busy) r_ovr <= 1'b1;

      // A load during HOLD with adj_ready=1 retires the old result and keeps adj_valid high
      if (w_load) begin
        r_pos   <= w_fin_pos;
        r_chg   <= w_apply ? w_fin_chg : 2'sb00;
        r_apply <= w_apply;
        r_state <= ST_HOLD;
      end else if ((r_state == ST_HOLD) && adj_ready) begin
        r_state <= ST_ACCUM;
      end
    end
  end

  assign adj_valid   = (r_state == ST_HOLD);
  assign adj_pos     = r_pos;
  assign adj_change  = r_chg;
  assign adj_apply   = r_apply;
  assign no_cand_err = r_no_cand;
  assign len_err     = r_len;
  assign overrun_err = r_ovr;

endmodule

// File: tb/tb_sbh_adjust_selector.sv
// Scoreboard bench for sbh_adjust_selector: expected results are queued as each
// group's final beat is driven and compared when the DUT presents them.
module tb_sbh_adjust_selector;

  localparam logic signed [31:0] SENT = 32'h7FFF_FFFF;

  typedef struct packed {
    logic [3:0] pos;
    logic [1:0] chg;
    logic       apply;
  } res_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               valid_in;
  logic signed [31:0] cost_in;
  logic signed [1:0]  change_in;
  logic               last_in;
  logic               hide_needed_in;
  logic               adj_valid;
  logic               adj_ready;
  logic [3:0]         adj_pos;
  logic signed [1:0]  adj_change;
  logic               adj_apply;
  logic               no_cand_err;
  logic               len_err;
  logic               overrun_err;

  logic signed [31:0] c [16];
  logic signed [1:0]  d [16];
  res_t               q [$];
  int                 n_cmp = 0;
  int                 n_mis = 0;

  sbh_adjust_selector #(.GROUP_SIZE(16), .COST_W(32), .POS_W(4)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .cost_in(cost_in),
    .change_in(change_in), .last_in(last_in), .hide_needed_in(hide_needed_in),
    .adj_valid(adj_valid), .adj_ready(adj_ready), .adj_pos(adj_pos),
    .adj_change(adj_change), .adj_apply(adj_apply), .no_cand_err(no_cand_err),
    .len_err(len_err), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1);
  end

  task automatic fill_sentinel();
    for (int i = 0; i < 16; i++) begin
      c[i] = SENT;
      d[i] = 2'sb01;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) begin
      int t;
      c[i] = $signed($urandom_range(0, 2000)) - 1000;
      t = $urandom_range(0, 2);
      d[i] = (t == 0) ? 2'sb11 : (t == 1) ? 2'sb00 : 2'sb01;
    end
  endtask

  // Drives n beats from c/d; pushes the modelled result unless it is expected to be dropped.
  task automatic run_group(input int n, input bit use_last, input bit hide,
                           input bit drop, input bit rdy_last);
    res_t               e;
    logic signed [31:0] m;
    int                 p;
    m = c[0];
    p = 0;
    for (int i = 1; i < n; i++)
      if (c[i] < m) begin
        m = c[i];
        p = i;
      end
    e.pos   = 4'(p);
    e.apply = hide && (m != SENT);
    e.chg   = e.apply ? d[p] : 2'b00;
    for (int i = 0; i < n; i++) begin
      valid_in       = 1'b1;
      cost_in        = c[i];
      change_in      = d[i];
      last_in        = use_last && (i == n - 1);
      hide_needed_in = hide;
      if (i == n - 1) begin
        if (rdy_last) begin
          adj_ready = 1'b1;
          if (q.size() > 0) void'(q.pop_front());
        end
        if (!drop) q.push_back(e);
      end
      @(posedge clk); #1;
    end
    valid_in  = 1'b0;
    last_in   = 1'b0;
    adj_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid_in = 1'b0; last_in = 1'b0; adj_ready = 1'b0;
    cost_in = '0; change_in = '0; hide_needed_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({adj_valid, adj_pos, adj_change, adj_apply} !== 8'h00) begin
      n_mis++;
      $display("FAIL reset_outputs: got %h, required 00", {adj_valid, adj_pos, adj_change, adj_apply});
    end
    n_cmp++;
    if ({no_cand_err, len_err, overrun_err} !== 3'b000) begin
      n_mis++;
      $display("FAIL reset_flags: got %b, required 000", {no_cand_err, len_err, overrun_err});
    end
  endtask

  task automatic test_min_select();
    fill_sentinel();
    c[5] = -3; d[5] = 2'sb01;
    c[9] = -7; d[9] = 2'sb11;
    run_group(16, 1, 1, 0, 0);
    n_cmp++;
    if (adj_valid !== 1'b1) begin
      n_mis++;
      $display("FAIL min_latency: adj_valid got %b, required 1", adj_valid);
    end
    n_cmp++;
    if ({adj_pos, adj_change, adj_apply} !== {4'd9, 2'b11, 1'b1}) begin
      n_mis++;
      $display("FAIL min_select: got %h, required %h", {adj_pos, adj_change, adj_apply}, {4'd9, 2'b11, 1'b1});
    end
    n_cmp++;
    if ({adj_pos, adj_change, adj_apply} !== q[0]) begin
      n_mis++;
      $display("FAIL min_scoreboard: got %h, required %h", {adj_pos, adj_change, adj_apply}, q[0]);
    end
    adj_ready = 1'b1;
    @(posedge clk); #1;
    adj_ready = 1'b0;
    void'(q.pop_front());
    n_cmp++;
    if (adj_valid !== 1'b0) begin
      n_mis++;
      $display("FAIL min_handshake: adj_valid got %b, required 0", adj_valid);
    end
  endtask

  task automatic test_tie();
    fill_random();
    for (int i = 0; i < 16; i++) if (c[i] < 0) c[i] = -c[i];
    c[2] = -4; c[11] = -4;
    run_group(16, 1, 1, 0, 0);
    n_cmp++;
    if (adj_pos !== 4'd2) begin
      n_mis++;
      $display("FAIL tie_pos: got %0d, required 2", adj_pos);
    end
    n_cmp++;
    if ({adj_pos, adj_change, adj_apply} !== q[0]) begin
      n_mis++;
      $display("FAIL tie_scoreboard: got %h, required %h", {adj_pos, adj_change, adj_apply}, q[0]);
    end
    adj_ready = 1'b1;
    @(posedge clk); #1;
    adj_ready = 1'b0;
    void'(q.pop_front());
  endtask

  task automatic test_hide_and_nocand();
    fill_random();
    run_group(16, 1, 0, 0, 0);
    n_cmp++;
    if ({adj_valid, adj_change, adj_apply, no_cand_err} !== 5'b10000) begin
      n_mis++;
      $display("FAIL no_hide: valid/chg/apply/nocand got %b, required 10000",
               {adj_valid, adj_change, adj_apply, no_cand_err});
    end
    n_cmp++;
    if ({adj_pos, adj_change, adj_apply} !== q[0]) begin
      n_mis++;
      $display("FAIL no_hide_scoreboard: got %h, required %h", {adj_pos, adj_change, adj_apply}, q[0]);
    end
    adj_ready = 1'b1;
    @(posedge clk); #1;
    adj_ready = 1'b0;
    void'(q.pop_front());
    fill_sentinel();
    run_group(16, 1, 1, 0, 0);
    n_cmp++;
    if ({adj_valid, adj_change, adj_apply, no_cand_err} !== 5'b10001) begin
      n_mis++;
      $display("FAIL no_cand: valid/chg/apply/nocand got %b, required 10001",
               {adj_valid, adj_change, adj_apply, no_cand_err});
    end
    adj_ready = 1'b1;
    @(posedge clk); #1;
    adj_ready = 1'b0;
    void'(q.pop_front());
  endtask

  task automatic test_random_groups();
    for (int g = 0; g < 6; g++) begin
      fill_random();
      run_group(16, 1, bit'($urandom_range(0, 1)), 0, 0);
      n_cmp++;
      if ({adj_valid, adj_pos, adj_change, adj_apply} !== {1'b1, q[0]}) begin
        n_mis++;
        $display("FAIL random_group%0d: got %h, required %h", g,
                 {adj_valid, adj_pos, adj_change, adj_apply}, {1'b1, q[0]});
      end
      adj_ready = 1'b1;
      @(posedge clk); #1;
      adj_ready = 1'b0;
      void'(q.pop_front());
    end
  endtask

  task automatic test_overrun();
    do_reset();
    fill_random();
    run_group(16, 1, 1, 0, 0);
    fill_sentinel();
    c[0] = -5000;
    run_group(16, 1, 1, 1, 0);
    n_cmp++;
    if ({adj_valid, adj_pos, adj_change, adj_apply} !== {1'b1, q[0]}) begin
      n_mis++;
      $display("FAIL overrun_hold: got %h, required %h",
               {adj_valid, adj_pos, adj_change, adj_apply}, {1'b1, q[0]});
    end
    n_cmp++;
    if (overrun_err !== 1'b1) begin
      n_mis++;
      $display("FAIL overrun_flag: got %b, required 1", overrun_err);
    end
    adj_ready = 1'b1;
    @(posedge clk); #1;
    adj_ready = 1'b0;
    void'(q.pop_front());
    n_cmp++;
    if (adj_valid !== 1'b0) begin
      n_mis++;
      $display("FAIL overrun_consume: adj_valid got %b, required 0", adj_valid);
    end
  endtask

  task automatic test_back_to_back();
    fill_random();
    run_group(16, 1, 1, 0, 0);
    n_cmp++;
    if ({adj_pos, adj_change, adj_apply} !== q[0]) begin
      n_mis++;
      $display("FAIL b2b_first: got %h, required %h", {adj_pos, adj_change, adj_apply}, q[0]);
    end
    fill_random();
    run_group(16, 1, 1, 0, 1);
    n_cmp++;
    if ({adj_valid, adj_pos, adj_change, adj_apply} !== {1'b1, q[0]}) begin
      n_mis++;
      $display("FAIL b2b_second: got %h, required %h",
               {adj_valid, adj_pos, adj_change, adj_apply}, {1'b1, q[0]});
    end
    adj_ready = 1'b1;
    @(posedge clk); #1;
    adj_ready = 1'b0;
    void'(q.pop_front());
  endtask

  task automatic test_length();
    do_reset();
    fill_random();
    run_group(10, 1, 1, 0, 0);
    n_cmp++;
    if ({len_err, adj_valid, adj_pos, adj_change, adj_apply} !== {2'b11, q[0]}) begin
      n_mis++;
      $display("FAIL len_short: got %h, required %h",
               {len_err, adj_valid, adj_pos, adj_change, adj_apply}, {2'b11, q[0]});
    end
    adj_ready = 1'b1;
    @(posedge clk); #1;
    adj_ready = 1'b0;
    void'(q.pop_front());
    do_reset();
    fill_random();
    run_group(16, 0, 1, 0, 0);
    n_cmp++;
    if ({len_err, adj_valid, adj_pos, adj_change, adj_apply} !== {2'b11, q[0]}) begin
      n_mis++;
      $display("FAIL len_long: got %h, required %h",
               {len_err, adj_valid, adj_pos, adj_change, adj_apply}, {2'b11, q[0]});
    end
    adj_ready = 1'b1;
    @(posedge clk); #1;
    adj_ready = 1'b0;
    void'(q.pop_front());
    fill_random();
    run_group(16, 1, 1, 0, 0);
    n_cmp++;
    if ({adj_pos, adj_change, adj_apply} !== q[0]) begin
      n_mis++;
      $display("FAIL len_wrap_next: got %h, required %h", {adj_pos, adj_change, adj_apply}, q[0]);
    end
    adj_ready = 1'b1;
    @(posedge clk); #1;
    adj_ready = 1'b0;
    void'(q.pop_front());
  endtask

  task automatic test_mid_reset();
    do_reset();
    fill_random();
    run_group(16, 1, 1, 0, 0);
    for (int i = 0; i < 7; i++) begin
      valid_in = 1'b1; cost_in = -32'sd1000 - i; change_in = 2'sb11; last_in = 1'b0;
      @(posedge clk); #1;
    end
    rst = 1'b1; cost_in = -32'sd2000;
    @(posedge clk); #1;
    n_cmp++;
    if ({adj_valid, adj_pos, adj_change, adj_apply, no_cand_err, len_err, overrun_err} !== 11'h000) begin
      n_mis++;
      $display("FAIL mid_reset_outputs: got %h, required 000",
               {adj_valid, adj_pos, adj_change, adj_apply, no_cand_err, len_err, overrun_err});
    end
    rst = 1'b0; valid_in = 1'b0;
    q.delete();
    fill_sentinel();
    c[12] = 5; d[12] = 2'sb01;
    run_group(16, 1, 1, 0, 0);
    n_cmp++;
    if ({adj_pos, adj_change, adj_apply} !== {4'd12, 2'b01, 1'b1}) begin
      n_mis++;
      $display("FAIL mid_reset_fresh: got %h, required %h", {adj_pos, adj_change, adj_apply}, {4'd12, 2'b01, 1'b1});
    end
    n_cmp++;
    if ({len_err, overrun_err, no_cand_err} !== 3'b000) begin
      n_mis++;
      $display("FAIL mid_reset_flags: got %b, required 000", {len_err, overrun_err, no_cand_err});
    end
    adj_ready = 1'b1;
    @(posedge clk); #1;
    adj_ready = 1'b0;
    void'(q.pop_front());
  endtask

  initial begin
    test_reset();
    test_min_select();
    test_tie();
    test_hide_and_nocand();
    test_random_groups();
    test_overrun();
    test_back_to_back();
    test_length();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
